// File: rtl/simplez_cpu.sv
// rtl/simplez_cpu.sv - Simplez 512x12 word-memory CPU core; SIMPLEZ_STEP_EN adds a single-step WAIT state.
// Memory reads and writes land on the falling edge, so every access here takes one clock period.
module simplez_cpu #(
    parameter logic [8:0] RESET_PC = 9'd0
) (
    input  logic        clk,
    input  logic        rstn,
`ifdef SIMPLEZ_STEP_EN
    input  logic        step,
`endif
    output logic [8:0]  mem_addr,
    output logic        mem_wr,
    input  logic [11:0] mem_din,
    output logic [11:0] mem_dout,
    output logic [11:0] acc,
    output logic        halt
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALTED
`ifdef SIMPLEZ_STEP_EN
        , S_WAIT
`endif
    } state_t;

`ifdef SIMPLEZ_STEP_EN
    localparam state_t S_NEXT = S_WAIT;
`else
    localparam state_t S_NEXT = S_FETCH;
`endif

    localparam logic [2:0] OP_ST   = 3'd0;
    localparam logic [2:0] OP_LD   = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_BR   = 3'd3;
    localparam logic [2:0] OP_BZ   = 3'd4;
    localparam logic [2:0] OP_CLR  = 3'd5;
    localparam logic [2:0] OP_DEC  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    state_t      state;
    logic [8:0]  pc;
    logic [11:0] ri;
    logic [11:0] a;
    logic [2:0]  op;
    logic [8:0]  cd;

    assign op = ri[11:9];
    assign cd = ri[8:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc    <= RESET_PC;
            ri    <= '0;
            a     <= '0;
            state <= S_NEXT;
        end else begin
            case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    ri    <= mem_din;
                    pc    <= pc + 9'd1;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    state <= S_NEXT;
                    case (op)
                        OP_LD, OP_ADD: state <= S_WB;
                        OP_BR:         pc <= cd;
                        // BZ sees A as left by the previous instruction
                        OP_BZ:         if (a == '0) pc <= cd;
                        OP_CLR:        a <= '0;
                        OP_DEC:        a <= a - 12'd1;
                        OP_HALT:       state <= S_HALTED;
                        default:       ;
                    endcase
                end
                S_WB: begin
                    a     <= (op == OP_LD) ? mem_din : a + mem_din;
                    state <= S_NEXT;
                end
                S_HALTED: state <= S_HALTED;
`ifdef SIMPLEZ_STEP_EN
                S_WAIT: if (step) state <= S_FETCH;
`endif
                default: state <= S_NEXT;
            endcase
        end
    end

    // Operand phases address CD; every other state keeps PC on the bus
    always_comb begin
        mem_addr = pc;
        if (state == S_EXEC || state == S_WB) mem_addr = cd;
    end

    assign mem_wr   = (state == S_EXEC) && (op == OP_ST);
    assign mem_dout = a;
    assign acc      = a;
    assign halt     = (state == S_HALTED);

endmodule
